// File: rtl/display_pkg.sv
// display_pkg: shared scan states and constants for the two-digit scanned display.
package display_pkg;

    typedef enum logic [3:0] {
        SHOW0  = 4'b0001,
        BLANK0 = 4'b0010,
        SHOW1  = 4'b0100,
        BLANK1 = 4'b1000
    } scan_state_t;

    localparam logic [1:0] AN_OFF        = 2'b11;
    localparam logic [3:0] DIGIT_DEFAULT = 4'h0;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: counts 0..limit-1 and flags the last cycle of the phase.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Terminal flag goes high on the final cycle of the current phase
    always_comb begin
        done = (count_q == (limit - CNT_W'(1)));
    end

    // Count upward, restarting from zero whenever the phase is closed
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear) begin
            count_d = '0;
        end
    end

    // Phase count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexes two hex digits onto one shared 7-segment
// decoder, driving active-low anodes with a blanking gap between digits.
module digit_scan_mux
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic       en,
    output logic [3:0] nibble,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(maxInt(DWELL_CYCLES, BLANK_CYCLES) + 1);

    if (DWELL_CYCLES < 1) begin : gBadDwell
        $error("digit_scan_mux: DWELL_CYCLES must be >= 1");
    end
    if (BLANK_CYCLES < 1) begin : gBadBlank
        $error("digit_scan_mux: BLANK_CYCLES must be >= 1");
    end

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [3:0]       sh0_q;
    logic [3:0]       sh0_d;
    logic [3:0]       sh1_q;
    logic [3:0]       sh1_d;
    logic [3:0]       nibble_q;
    logic [3:0]       nibble_d;
    logic [1:0]       an_q;
    logic [1:0]       an_d;
    logic             frame_tick_q;
    logic             frame_tick_d;
    logic [CNT_W-1:0] phaseLimit;
    logic             phaseDone;
    logic             frameStart;

    // Show phases last the dwell time, blank phases the blanking time
    always_comb begin
        phaseLimit = CNT_W'(BLANK_CYCLES);
        if ((state_q == SHOW0) || (state_q == SHOW1)) begin
            phaseLimit = CNT_W'(DWELL_CYCLES);
        end
    end

    phase_timer #(
        .CNT_W(CNT_W)
    ) uPhaseTimer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (phaseDone),
        .limit  (phaseLimit),
        .done   (phaseDone)
    );

    // A new frame starts when the trailing blank of the left digit expires
    always_comb begin
        frameStart = (state_q == BLANK1) && phaseDone;
    end

    // State register; reset parks in the trailing blank so the first frame
    // starts after one blanking interval
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BLANK1;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed rotation through the four phases, stepping on phase expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW0:   if (phaseDone) state_d = BLANK0;
            BLANK0:  if (phaseDone) state_d = SHOW1;
            SHOW1:   if (phaseDone) state_d = BLANK1;
            BLANK1:  if (phaseDone) state_d = SHOW0;
            default: state_d = BLANK1;
        endcase
    end

    // Next outputs follow the next state, so the nibble changes on blank
    // entry and the decoder has settled before the following anode turns on
    always_comb begin
        sh0_d        = frameStart ? digit0 : sh0_q;
        sh1_d        = frameStart ? digit1 : sh1_q;
        an_d         = AN_OFF;
        nibble_d     = sh0_d;
        frame_tick_d = 1'b0;
        case (state_d)
            SHOW0: begin
                an_d         = ~{1'b0, en};
                nibble_d     = sh0_d;
                frame_tick_d = frameStart;
            end
            BLANK0: begin
                nibble_d = sh1_d;
            end
            SHOW1: begin
                an_d     = ~{en, 1'b0};
                nibble_d = sh1_d;
            end
            BLANK1: begin
                nibble_d = sh0_d;
            end
            default: begin
                an_d = AN_OFF;
            end
        endcase
    end

    // Output and shadow registers share the state register's edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh0_q        <= DIGIT_DEFAULT;
            sh1_q        <= DIGIT_DEFAULT;
            nibble_q     <= DIGIT_DEFAULT;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            sh0_q        <= sh0_d;
            sh1_q        <= sh1_d;
            nibble_q     <= nibble_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign nibble     = nibble_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

    // Both PNP drivers on at once would short the two digits together
    anodeExclusive: assert property (@(posedge clk) disable iff (!reset_n) an_q != 2'b00)
        else $error("digit_scan_mux: both anodes enabled");

endmodule
